// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: 256-word data RAM, memory-mapped timer and LED
// register, and the registered write-back bundle.
module mem_wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_mem,
    input  logic        MemWrite_mem,
    input  logic [31:0] ALUResult_mem,
    input  logic [31:0] MemWriteData_mem,
    input  logic [1:0]  MemtoReg_mem,
    input  logic        RegWrite_mem,
    input  logic [4:0]  RegWriteAddr_mem,
    input  logic [31:0] PC_4_mem,
    input  logic [31:0] PC_IRQ_mem,
    output logic        RegWrite_wb,
    output logic [4:0]  RegWriteAddr_wb,
    output logic [31:0] RegWriteData_wb,
    output logic        irq,
    output logic [7:0]  led
);

    logic [31:0] ram_q [0:255];
    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic        rw_q, rw_d;
    logic [4:0]  ra_q, ra_d;
    logic [31:0] wd_q, wd_d;

    logic [29:0] word_addr;
    logic        sel_ram, sel_th, sel_tl, sel_tcon, sel_led;
    logic        wr_en;
    logic [31:0] rd_data;
    logic [31:0] load_data;

    assign word_addr = ALUResult_mem[31:2];
    assign sel_ram   = (ALUResult_mem[31:10] == 22'd0);
    assign sel_th    = (word_addr == 30'h1000_0000);
    assign sel_tl    = (word_addr == 30'h1000_0001);
    assign sel_tcon  = (word_addr == 30'h1000_0002);
    assign sel_led   = (word_addr == 30'h1000_0003);
    assign wr_en     = MemWrite_mem && !reset;

    // Combinational read of the pre-store state, so a same-cycle store is not visible.
    always_comb begin
        rd_data = 32'd0;
        if (sel_ram)       rd_data = ram_q[ALUResult_mem[9:2]];
        else if (sel_th)   rd_data = th_q;
        else if (sel_tl)   rd_data = tl_q;
        else if (sel_tcon) rd_data = {29'd0, tcon_q};
        else if (sel_led)  rd_data = {24'd0, led_q};
    end

    assign load_data = MemRead_mem ? rd_data : 32'd0;

    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        led_d  = led_q;
        if (tcon_q[0]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                if (tcon_q[1]) tcon_d[2] = 1'b1;
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end
        // CPU stores override the timer's own update.
        if (wr_en) begin
            if (sel_th)   th_d   = MemWriteData_mem;
            if (sel_tl)   tl_d   = MemWriteData_mem;
            if (sel_tcon) tcon_d = MemWriteData_mem[2:0];
            if (sel_led)  led_d  = MemWriteData_mem[7:0];
        end
    end

    always_comb begin
        rw_d = RegWrite_mem;
        ra_d = RegWriteAddr_mem;
        case (MemtoReg_mem)
            2'b00:   wd_d = ALUResult_mem;
            2'b01:   wd_d = load_data;
            2'b10:   wd_d = PC_4_mem;
            default: wd_d = PC_IRQ_mem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q   <= 32'd0;
            tl_q   <= 32'd0;
            tcon_q <= 3'd0;
            led_q  <= 8'd0;
            rw_q   <= 1'b0;
            ra_q   <= 5'd0;
            wd_q   <= 32'd0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            led_q  <= led_d;
            rw_q   <= rw_d;
            ra_q   <= ra_d;
            wd_q   <= wd_d;
        end
    end

    // RAM has no reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en && sel_ram) ram_q[ALUResult_mem[9:2]] <= MemWriteData_mem;
    end

    assign RegWrite_wb     = rw_q;
    assign RegWriteAddr_wb = ra_q;
    assign RegWriteData_wb = wd_q;
    assign irq             = tcon_q[1] & tcon_q[2];
    assign led             = led_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios then random traffic, checked
// against a memory-map model kept as plain arrays and variables.
module tb_mem_wb_stage;

    logic        clk;
    logic        reset;
    logic        MemRead_mem;
    logic        MemWrite_mem;
    logic [31:0] ALUResult_mem;
    logic [31:0] MemWriteData_mem;
    logic [1:0]  MemtoReg_mem;
    logic        RegWrite_mem;
    logic [4:0]  RegWriteAddr_mem;
    logic [31:0] PC_4_mem;
    logic [31:0] PC_IRQ_mem;
    logic        RegWrite_wb;
    logic [4:0]  RegWriteAddr_wb;
    logic [31:0] RegWriteData_wb;
    logic        irq;
    logic [7:0]  led;

    mem_wb_stage dut (
        .clk              (clk),
        .reset            (reset),
        .MemRead_mem      (MemRead_mem),
        .MemWrite_mem     (MemWrite_mem),
        .ALUResult_mem    (ALUResult_mem),
        .MemWriteData_mem (MemWriteData_mem),
        .MemtoReg_mem     (MemtoReg_mem),
        .RegWrite_mem     (RegWrite_mem),
        .RegWriteAddr_mem (RegWriteAddr_mem),
        .PC_4_mem         (PC_4_mem),
        .PC_IRQ_mem       (PC_IRQ_mem),
        .RegWrite_wb      (RegWrite_wb),
        .RegWriteAddr_wb  (RegWriteAddr_wb),
        .RegWriteData_wb  (RegWriteData_wb),
        .irq              (irq),
        .led              (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;

    int checks = 0;
    int errors = 0;

    // Reference state of the memory map
    logic [31:0] m_mem [0:255];
    logic [31:0] m_th, m_tl;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic        e_rw;
    logic [4:0]  e_ra;
    logic [31:0] e_wd;

    function automatic logic [31:0] mread(input logic [31:0] wa);
        if (wa < 32'h0000_0400) return m_mem[wa[9:2]];
        if (wa == A_TH)         return m_th;
        if (wa == A_TL)         return m_tl;
        if (wa == A_TCON)       return {29'd0, m_tcon};
        if (wa == A_LED)        return {24'd0, m_led};
        return 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, then compare after the edge.
    task automatic cyc(input logic rst, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] m2r, input logic rw, input logic [4:0] ra,
                       input logic [31:0] pc4, input logic [31:0] pcirq);
        logic [31:0] wa, ld, ntl;
        logic [2:0]  ntcon;
        reset = rst; MemRead_mem = rd; MemWrite_mem = wr;
        ALUResult_mem = addr; MemWriteData_mem = wdata; MemtoReg_mem = m2r;
        RegWrite_mem = rw; RegWriteAddr_mem = ra; PC_4_mem = pc4; PC_IRQ_mem = pcirq;
        wa = {addr[31:2], 2'b00};
        ld = rd ? mread(wa) : 32'd0;
        if (rst) begin
            e_rw = 1'b0; e_ra = 5'd0; e_wd = 32'd0;
            m_th = 32'd0; m_tl = 32'd0; m_tcon = 3'd0; m_led = 8'd0;
        end else begin
            e_rw = rw; e_ra = ra;
            case (m2r)
                2'd0:    e_wd = addr;
                2'd1:    e_wd = ld;
                2'd2:    e_wd = pc4;
                default: e_wd = pcirq;
            endcase
            ntl = m_tl; ntcon = m_tcon;
            if (m_tcon[0]) begin
                if (m_tl == 32'hFFFF_FFFF) begin
                    ntl = m_th;
                    if (m_tcon[1]) ntcon[2] = 1'b1;
                end else begin
                    ntl = m_tl + 32'd1;
                end
            end
            if (wr) begin
                if (wa < 32'h0000_0400) m_mem[wa[9:2]] = wdata;
                else if (wa == A_TH)    m_th = wdata;
                else if (wa == A_TL)    ntl = wdata;
                else if (wa == A_TCON)  ntcon = wdata[2:0];
                else if (wa == A_LED)   m_led = wdata[7:0];
            end
            m_tl = ntl; m_tcon = ntcon;
        end
        @(posedge clk);
        #1;
        chk("rw_wb", {31'd0, RegWrite_wb}, {31'd0, e_rw});
        chk("ra_wb", {27'd0, RegWriteAddr_wb}, {27'd0, e_ra});
        chk("wd_wb", RegWriteData_wb, e_wd);
        chk("irq", {31'd0, irq}, {31'd0, m_tcon[1] & m_tcon[2]});
        chk("led", {24'd0, led}, {24'd0, m_led});
    endtask

    task automatic st(input logic [31:0] addr, input logic [31:0] data);
        cyc(1'b0, 1'b0, 1'b1, addr, data, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic ld_wb(input logic [31:0] addr, input logic [4:0] ra);
        cyc(1'b0, 1'b1, 1'b0, addr, 32'd0, 2'd1, 1'b1, ra, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] a, d;
        int k;
        m_th = 32'd0; m_tl = 32'd0; m_tcon = 3'd0; m_led = 8'd0;

        // Reset with junk on the inputs
        cyc(1'b1, 1'b1, 1'b1, A_LED, 32'hFFFF_FFFF, 2'd3, 1'b1, 5'd31, 32'h1, 32'h2);
        chk("reset_wd", RegWriteData_wb, 32'd0);
        chk("reset_led", {24'd0, led}, 32'd0);

        // Fill the RAM so every later load has a defined value
        for (int i = 0; i < 256; i++) st(i * 4, $urandom);

        // Store then load back
        st(32'h0000_0010, 32'hDEAD_BEEF);
        ld_wb(32'h0000_0010, 5'd5);
        chk("st_ld_data", RegWriteData_wb, 32'hDEAD_BEEF);
        chk("st_ld_addr", {27'd0, RegWriteAddr_wb}, 32'd5);
        chk("st_ld_rw", {31'd0, RegWrite_wb}, 32'd1);

        // Link value selection
        cyc(1'b0, 1'b0, 1'b0, 32'h1234, 32'd0, 2'd2, 1'b1, 5'd31, 32'h0040_0008, 32'h8000_0004);
        chk("sel_pc4", RegWriteData_wb, 32'h0040_0008);
        cyc(1'b0, 1'b0, 1'b0, 32'h1234, 32'd0, 2'd3, 1'b1, 5'd31, 32'h0040_0008, 32'h8000_0004);
        chk("sel_pcirq", RegWriteData_wb, 32'h8000_0004);

        // Same-cycle load and store returns the old word, next load sees the new one
        st(32'h0000_0020, 32'h1111_1111);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0022, 32'h2222_2222, 2'd1, 1'b1, 5'd3, 32'd0, 32'd0);
        chk("rw_same_old", RegWriteData_wb, 32'h1111_1111);
        ld_wb(32'h0000_0021, 5'd3);
        chk("rw_same_new", RegWriteData_wb, 32'h2222_2222);

        // Timer reload and interrupt
        st(A_TH, 32'hFFFF_FFFE);
        st(A_TL, 32'hFFFF_FFFE);
        st(A_TCON, 32'd3);
        ld_wb(A_TL, 5'd1);
        chk("tl_start", RegWriteData_wb, 32'hFFFF_FFFE);
        chk("irq_not_yet", {31'd0, irq}, 32'd0);
        ld_wb(A_TL, 5'd1);
        chk("tl_max", RegWriteData_wb, 32'hFFFF_FFFF);
        chk("irq_set", {31'd0, irq}, 32'd1);
        ld_wb(A_TL, 5'd1);
        chk("tl_reload", RegWriteData_wb, 32'hFFFF_FFFE);
        ld_wb(A_TCON, 5'd2);
        chk("tcon_read", RegWriteData_wb, 32'd7);
        st(A_TCON, 32'd1);
        chk("irq_clear", {31'd0, irq}, 32'd0);

        // Store to TL while running beats the increment
        st(A_TL, 32'h0000_0100);
        ld_wb(A_TL, 5'd4);
        chk("tl_store_wins", RegWriteData_wb, 32'h0000_0100);
        st(A_TCON, 32'd0);

        // Unmapped load, LED store
        ld_wb(32'h5000_0000, 5'd6);
        chk("unmapped_ld", RegWriteData_wb, 32'd0);
        st(A_LED, 32'h0000_005A);
        chk("led_store", {24'd0, led}, 32'h5A);

        // Reset mid-stream with irq pending and the timer running
        st(A_TL, 32'hFFFF_FFFF);
        st(A_TCON, 32'd3);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        chk("irq_before_rst", {31'd0, irq}, 32'd1);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h0BAD_0BAD, 2'd0, 1'b1, 5'd9, 32'd0, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_wd", RegWriteData_wb, 32'd0);
        chk("rst_rw", {31'd0, RegWrite_wb}, 32'd0);
        ld_wb(A_TL, 5'd7);
        chk("rst_tl", RegWriteData_wb, 32'd0);
        ld_wb(32'h0000_0010, 5'd8);
        chk("ram_kept", RegWriteData_wb, 32'hDEAD_BEEF);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            k = $urandom_range(0, 10);
            case (k)
                6:       a = A_TH;
                7:       a = A_TL;
                8:       a = A_TCON;
                9:       a = A_LED;
                10:      a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
                default: a = {22'd0, 8'($urandom), 2'b00};
            endcase
            a = a | 32'($urandom_range(0, 3));
            d = $urandom;
            if (k == 6 || k == 7) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            cyc(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), a, d,
                2'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: ports clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 MemRead_mem  input  1  load request this cycle.
REQ-005 MemWrite_mem  input  1  store request this cycle.
REQ-006 ALUResult_mem  input  32  byte address for load/store; also the ALU write-back value.
REQ-007 MemWriteData_mem  input  32  store data.
REQ-008 MemtoReg_mem  input  2  write-back select: 00 ALU, 01 load data, 10 PC_4, 11 PC_IRQ.
REQ-009 RegWrite_mem, RegWriteAddr_mem  input  1, 5  register-file write enable and destination.
REQ-010 PC_4_mem, PC_IRQ_mem  input  32, 32  link values for write-back.
REQ-011 RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb  output  1, 5, 32  registered write-back bundle.
REQ-012 irq  output  1  timer interrupt request, combinational from state (TCON[1] & TCON[2]).
REQ-013 led  output  8  registered LED register.

Function
REQ-014 Address map SHALL be: RAM 0x0000_0000-0x0000_03FF (256 x 32, word index ALUResult_mem[9:2]); TH 0x4000_0000; TL 0x4000_0004; TCON 0x4000_0008 (bits [2:0]); LED 0x4000_000C (bits [7:0]).
REQ-015 Address bits [1:0] SHALL be ignored; only word accesses are supported.
REQ-016 Loads SHALL read combinationally; the value SHALL be captured into RegWriteData_wb on the same rising edge (load-to-WB latency 1 cycle).
REQ-017 Stores SHALL commit on the rising edge of the cycle in which MemWrite_mem=1.
REQ-018 Unmapped loads SHALL return 0; unmapped stores SHALL be ignored.
REQ-019 Simultaneous MemRead_mem and MemWrite_mem to the same address SHALL commit the store and return the pre-store value.
REQ-020 A load in the cycle after a store to the same address SHALL return the stored value.
REQ-021 Timer: when TCON[0]=1, TL SHALL increment by 1 per cycle; when TL=0xFFFF_FFFF, the next TL SHALL be TH and, if TCON[1]=1, TCON[2] SHALL be set.
REQ-022 A CPU store to TL or TCON SHALL take priority over timer update in that cycle; a store to TCON writing bit 2 = 0 SHALL clear the pending interrupt.
REQ-023 Reads of TCON SHALL return {29'b0, TCON[2:0]}; reads of LED SHALL return {24'b0, led}.
REQ-024 Each cycle, RegWrite_wb <= RegWrite_mem and RegWriteAddr_wb <= RegWriteAddr_mem; RegWriteData_wb <= the source selected by MemtoReg_mem.
REQ-025 The block SHALL have no stall or flush input; every input is consumed every cycle.

Reset
REQ-026 On reset, RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb, TH, TL, TCON, and led SHALL be 0, and irq SHALL therefore be 0.
REQ-027 On reset, stores SHALL be suppressed in that cycle; RAM contents SHALL NOT be cleared.
REQ-028 Reset asserted with the timer running SHALL stop the count on that edge, with TL=0 the following cycle.

Verification
REQ-029 Store 0xDEADBEEF to 0x0000_0010, then next cycle load 0x0000_0010 with MemtoReg=01, RegWrite=1, addr=5 -> following cycle RegWriteData_wb=0xDEADBEEF, RegWriteAddr_wb=5, RegWrite_wb=1.
REQ-030 MemtoReg=10, PC_4_mem=0x0040_0008 -> RegWriteData_wb=0x0040_0008 one cycle later; MemtoReg=11, PC_IRQ_mem=0x8000_0004 -> 0x8000_0004.
REQ-031 TH=0xFFFF_FFFE, TL=0xFFFF_FFFE, TCON=3 -> TL=0xFFFF_FFFF after 1 cycle; after 2 cycles TL=0xFFFF_FFFE and irq=1; store TCON=1 -> irq=0 next cycle.
REQ-032 Store to TL while TCON[0]=1 -> TL equals the stored value next cycle, with no increment that cycle.
REQ-033 Load 0x5000_0000 -> RegWriteData_wb=0; store 0x5A to 0x4000_000C -> led=0x5A next cycle.
REQ-034 Assert reset for one cycle mid-stream with irq=1 -> all outputs 0 next cycle, and RAM word 0x10 still reads 0xDEADBEEF.
